// File: rtl/keypad_entry_ctrl.sv
// Keypad digit entry controller: collects four BCD digits from a 10-line keypad.
// Define KEYPAD_DEBOUNCE_EN to require DEB_CYCLES stable samples before a key is accepted.
module keypad_entry_ctrl #(
    parameter int DEB_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  key,
    input  logic        clr,
    input  logic        ack,
    output logic [15:0] digits,
    output logic [2:0]  count,
    output logic        valid,
    output logic        key_evt,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HELD     = 2'd1,
`ifdef KEYPAD_DEBOUNCE_EN
        ST_FULL     = 2'd2,
        ST_DEBOUNCE = 2'd3
`else
        ST_FULL     = 2'd2
`endif
    } state_t;

    state_t      state_r, state_nxt_s;
    logic        single_s, multi_s, none_s;
    logic [3:0]  code_s;
    logic        accept_s, err_pulse_s, clear_s;
    logic [15:0] digits_r;
    logic [2:0]  count_r;
    logic        valid_r, key_evt_r, err_r;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam logic [3:0] DEB_LIM       = 4'(DEB_CYCLES);
    localparam bit         DEB_IMMEDIATE = (DEB_CYCLES <= 1);
    logic [3:0] deb_cnt_r, deb_cnt_nxt_s;
    logic [3:0] code_r, code_nxt_s;
    logic       same_key_s, deb_done_s;

    assign same_key_s = single_s && (code_s == code_r);
    assign deb_done_s = ((deb_cnt_r + 4'd1) == DEB_LIM);
`endif

    // Key classification: one-hot patterns are single presses and map to their BCD code
    always_comb begin
        single_s = 1'b1;
        code_s   = 4'd0;
        case (key)
            10'b00_0000_0001: code_s = 4'd0;
            10'b00_0000_0010: code_s = 4'd1;
            10'b00_0000_0100: code_s = 4'd2;
            10'b00_0000_1000: code_s = 4'd3;
            10'b00_0001_0000: code_s = 4'd4;
            10'b00_0010_0000: code_s = 4'd5;
            10'b00_0100_0000: code_s = 4'd6;
            10'b00_1000_0000: code_s = 4'd7;
            10'b01_0000_0000: code_s = 4'd8;
            10'b10_0000_0000: code_s = 4'd9;
            default:          single_s = 1'b0;
        endcase
        none_s  = (key == 10'd0);
        multi_s = !none_s && !single_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; clear forces IDLE from anywhere
    always_comb begin
        state_nxt_s = state_r;
        if (clr) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (single_s) begin
`ifdef KEYPAD_DEBOUNCE_EN
                        state_nxt_s = DEB_IMMEDIATE ? ST_HELD : ST_DEBOUNCE;
`else
                        state_nxt_s = ST_HELD;
`endif
                    end else if (multi_s) begin
                        state_nxt_s = ST_HELD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
`ifdef KEYPAD_DEBOUNCE_EN
                ST_DEBOUNCE: begin
                    if (same_key_s) begin
                        state_nxt_s = deb_done_s ? ST_HELD : ST_DEBOUNCE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
`endif
                ST_HELD: begin
                    if (none_s) begin
                        state_nxt_s = (count_r == 3'd4) ? ST_FULL : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_HELD;
                    end
                end
                ST_FULL: begin
                    if (ack) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Action decode: accept/err/clear strobes and debounce bookkeeping
    always_comb begin
        accept_s    = 1'b0;
        err_pulse_s = 1'b0;
        clear_s     = 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
        deb_cnt_nxt_s = 4'd0;
        code_nxt_s    = code_r;
`endif
        if (clr) begin
            clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (single_s) begin
`ifdef KEYPAD_DEBOUNCE_EN
                        if (DEB_IMMEDIATE) begin
                            accept_s = 1'b1;
                        end else begin
                            deb_cnt_nxt_s = 4'd1;
                            code_nxt_s    = code_s;
                        end
`else
                        accept_s = 1'b1;
`endif
                    end else if (multi_s) begin
                        err_pulse_s = 1'b1;
                    end else begin
                        err_pulse_s = 1'b0;
                    end
                end
`ifdef KEYPAD_DEBOUNCE_EN
                ST_DEBOUNCE: begin
                    if (same_key_s && deb_done_s) begin
                        accept_s = 1'b1;
                    end else if (same_key_s) begin
                        deb_cnt_nxt_s = deb_cnt_r + 4'd1;
                    end else begin
                        deb_cnt_nxt_s = 4'd0;
                    end
                end
`endif
                ST_FULL: begin
                    if (ack) begin
                        clear_s = 1'b1;
                    end else begin
                        clear_s = 1'b0;
                    end
                end
                default: begin
                    accept_s = 1'b0;
                end
            endcase
        end
    end

    // Entry buffer and registered output strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_r  <= 16'h0000;
            count_r   <= 3'd0;
            valid_r   <= 1'b0;
            key_evt_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            key_evt_r <= accept_s;
            err_r     <= err_pulse_s;
            if (clear_s) begin
                digits_r <= 16'h0000;
                count_r  <= 3'd0;
                valid_r  <= 1'b0;
            end else if (accept_s) begin
                digits_r <= {digits_r[11:0], code_s};
                count_r  <= count_r + 3'd1;
                valid_r  <= (count_r == 3'd3);
            end else begin
                digits_r <= digits_r;
                count_r  <= count_r;
                valid_r  <= valid_r;
            end
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    // Debounce counter and latched candidate code
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt_r <= 4'd0;
            code_r    <= 4'd0;
        end else begin
            deb_cnt_r <= deb_cnt_nxt_s;
            code_r    <= code_nxt_s;
        end
    end
`endif

    assign digits  = digits_r;
    assign count   = count_r;
    assign valid   = valid_r;
    assign key_evt = key_evt_r;
    assign err     = err_r;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl; adapts hold lengths to whether
// KEYPAD_DEBOUNCE_EN is defined (DEB_CYCLES = 4).
module tb_keypad_entry_ctrl;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int ACC = 4;
`else
    localparam int ACC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  key = 10'd0;
    logic        clr = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        valid, key_evt, err;

    int n_checks = 0;
    int n_errors = 0;
    int evt_cnt  = 0;
    int err_cnt  = 0;
    int evt_base;

    keypad_entry_ctrl #(.DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .key(key), .clr(clr), .ack(ack),
        .digits(digits), .count(count), .valid(valid),
        .key_evt(key_evt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample just after it
    task automatic step();
        @(posedge clk);
        #1;
        if (key_evt) evt_cnt++;
        if (err) err_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Hold digit n long enough to be accepted, then release for one edge
    task automatic press(input int n);
        key = 10'b1 << n;
        repeat (ACC) step();
        key = 10'd0;
        step();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_digits"}, {16'd0, digits}, 32'h0000);
        check_eq({tag, "_count"}, {29'd0, count}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check_eq({tag, "_key_evt"}, {31'd0, key_evt}, 32'd0);
        check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        key = 10'h3FF;
        clr = 1'b1;
        ack = 1'b1;
        step();
        step();
        check_zero("reset");
        key = 10'd0; clr = 1'b0; ack = 1'b0;
        rst = 1'b0;
        step();

        // Single key 7 accepted on the ACC-th edge
        key = 10'b1 << 7;
        repeat (ACC - 1) step();
        check_eq("k7_pre_count", {29'd0, count}, 32'd0);
        step();
        check_eq("k7_digits", {16'd0, digits}, 32'h0007);
        check_eq("k7_count", {29'd0, count}, 32'd1);
        check_eq("k7_evt", {31'd0, key_evt}, 32'd1);
        step();
        check_eq("k7_evt_once", {31'd0, key_evt}, 32'd0);
        key = 10'd0;
        step();

        // Short burst rejected, long hold yields exactly one digit
        do_reset();
        evt_base = evt_cnt;
`ifdef KEYPAD_DEBOUNCE_EN
        key = 10'b1 << 3;
        repeat (3) step();
        key = 10'd0;
        step();
        check_eq("burst_count", {29'd0, count}, 32'd0);
        check_eq("burst_evts", evt_cnt - evt_base, 32'd0);
`endif
        key = 10'b1 << 3;
        repeat (10) step();
        key = 10'd0;
        step();
        check_eq("hold_evts", evt_cnt - evt_base, 32'd1);
        check_eq("hold_count", {29'd0, count}, 32'd1);
        check_eq("hold_digit", {28'd0, digits[3:0]}, 32'd3);

        // Four-digit entry, freeze in FULL, ack clears
        do_reset();
        press(1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_eq("ack_ignored_count", {29'd0, count}, 32'd1);
        press(9);
        press(0);
        press(5);
        check_eq("full_digits", {16'd0, digits}, 32'h1905);
        check_eq("full_count", {29'd0, count}, 32'd4);
        check_eq("full_valid", {31'd0, valid}, 32'd1);
        evt_base = evt_cnt;
        press(2);
        press(2);
        key = 10'b00_0100_0100;
        repeat (3) step();
        key = 10'd0;
        step();
        check_eq("frozen_digits", {16'd0, digits}, 32'h1905);
        check_eq("frozen_count", {29'd0, count}, 32'd4);
        check_eq("frozen_evts", evt_cnt - evt_base, 32'd0);
        check_eq("frozen_errs", err_cnt, 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check_eq("ack_digits", {16'd0, digits}, 32'h0000);
        check_eq("ack_count", {29'd0, count}, 32'd0);
        check_eq("ack_valid", {31'd0, valid}, 32'd0);

        // Multi-key press
        do_reset();
        evt_base = evt_cnt;
        key = 10'b00_0100_0100;
        step();
        check_eq("multi_err", {31'd0, err}, 32'd1);
        repeat (5) step();
        check_eq("multi_err_once", err_cnt, 32'd1);
        check_eq("multi_no_digit", {29'd0, count}, 32'd0);
        key = 10'd0;
        step();
        press(4);
        check_eq("after_multi_digit", {28'd0, digits[3:0]}, 32'd4);
        check_eq("after_multi_count", {29'd0, count}, 32'd1);
        check_eq("multi_evts", evt_cnt - evt_base, 32'd1);

        // clr beats ack in FULL
        do_reset();
        press(2); press(0); press(2); press(6);
        check_eq("full2_valid", {31'd0, valid}, 32'd1);
        clr = 1'b1; ack = 1'b1;
        step();
        clr = 1'b0; ack = 1'b0;
        check_zero("clr_ack");

        // clr beats digit acceptance on the same edge
        evt_base = evt_cnt;
        key = 10'b1 << 5;
        repeat (ACC - 1) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        key = 10'd0;
        step();
        check_eq("clr_accept_count", {29'd0, count}, 32'd0);
        check_eq("clr_accept_evts", evt_cnt - evt_base, 32'd0);

        // Reset mid-entry discards partial state; debounce restarts
        press(8);
        key = 10'b1 << 5;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("rst_mid");
        evt_base = evt_cnt;
        repeat (ACC - 1) step();
        check_eq("rst_restart_evts", evt_cnt - evt_base, 32'd0);
        key = 10'd0;
        step();

        // Reset while FULL
        press(3); press(3); press(3); press(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero("rst_full");

        // Key 8 for one edge: accepted only without debounce
        key = 10'b1 << 8;
        step();
        key = 10'd0;
`ifdef KEYPAD_DEBOUNCE_EN
        check_eq("k8_rejected_evt", {31'd0, key_evt}, 32'd0);
        check_eq("k8_rejected_count", {29'd0, count}, 32'd0);
`else
        check_eq("k8_digit", {28'd0, digits[3:0]}, 32'd8);
        check_eq("k8_evt", {31'd0, key_evt}, 32'd1);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
